// File: rtl/floor_scroller.sv
// floor_scroller: three floors scroll upward once per frame edge; a floor leaving the top
// respawns at the bottom with an LFSR-chosen gap. Optional macro FLOOR_SPEEDUP_EN adds speed-up.
module floor_scroller #(
    parameter int unsigned SPACING   = 150,
    parameter int unsigned SPAN      = 450,
    parameter logic [9:0]  LFSR_SEED = 10'h2A5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    output logic [29:0] floorsYPos,
    output logic [29:0] gapsPos,
    output logic [29:0] gapsWidth,
    output logic [2:0]  speed,
    output logic [9:0]  floorsPassed
);

    typedef enum logic {IDLE, RUN} stateT;

    localparam logic [9:0] INIT_GAP   [3] = '{10'd200, 10'd300, 10'd150};
    localparam logic [9:0] INIT_WIDTH [3] = '{10'd40, 10'd35, 10'd60};

    function automatic logic [9:0] initY(input int unsigned idx);
        return 10'(100 + idx * SPACING);
    endfunction

    stateT       state;
    logic        frameD;
    logic        frameEdge;
    logic [9:0]  yPos     [3];
    logic [9:0]  gapPos   [3];
    logic [9:0]  gapWidth [3];
    logic [9:0]  nextY    [3];
    logic [2:0]  wrap;
    logic [1:0]  nWraps;
    logic [9:0]  lfsr;
    logic [9:0]  step;
    logic [10:0] passSum;
    logic [9:0]  passNext;
    logic [2:0]  speedReg;

`ifdef FLOOR_SPEEDUP_EN
    logic [3:0] wrapCnt;
    logic [4:0] wrapSum;
    assign wrapSum = {1'b0, wrapCnt} + {3'd0, nWraps};
`else
    assign speedReg = 3'd1;
`endif

    assign frameEdge  = frame & ~frameD;
    assign speed      = speedReg;
    assign floorsYPos = {yPos[0], yPos[1], yPos[2]};
    assign gapsPos    = {gapPos[0], gapPos[1], gapPos[2]};
    assign gapsWidth  = {gapWidth[0], gapWidth[1], gapWidth[2]};

    always_comb begin
        step   = {7'd0, speedReg};
        nWraps = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            wrap[i]  = yPos[i] < step;
            nextY[i] = wrap[i] ? yPos[i] + 10'(SPAN) - step : yPos[i] - step;
            nWraps   = nWraps + {1'b0, wrap[i]};
        end
        passSum  = {1'b0, floorsPassed} + {9'd0, nWraps};
        passNext = (passSum > 11'd999) ? 10'd999 : passSum[9:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            frameD       <= 1'b0;
            lfsr         <= LFSR_SEED;
            floorsPassed <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                yPos[i]     <= initY(i);
                gapPos[i]   <= INIT_GAP[i];
                gapWidth[i] <= INIT_WIDTH[i];
            end
`ifdef FLOOR_SPEEDUP_EN
            speedReg <= 3'd1;
            wrapCnt  <= '0;
`endif
        end else begin
            frameD <= frame;
            if (stop) begin
                // LFSR deliberately keeps running so the next game differs
                state        <= IDLE;
                floorsPassed <= '0;
                for (int unsigned i = 0; i < 3; i++) begin
                    yPos[i]     <= initY(i);
                    gapPos[i]   <= INIT_GAP[i];
                    gapWidth[i] <= INIT_WIDTH[i];
                end
`ifdef FLOOR_SPEEDUP_EN
                speedReg <= 3'd1;
                wrapCnt  <= '0;
`endif
            end else begin
                case (state)
                    IDLE: if (start) state <= RUN;
                    RUN: if (frameEdge && !pause) begin
                        floorsPassed <= passNext;
                        for (int unsigned i = 0; i < 3; i++) begin
                            yPos[i] <= nextY[i];
                            if (wrap[i]) begin
                                gapPos[i]   <= 10'd40 + {1'b0, lfsr[8:0]};
                                gapWidth[i] <= 10'd30 + {5'd0, lfsr[4:0]};
                            end
                        end
                        // Advance only on updates that consumed a value, so the first wrap sees the seed
                        if (|wrap) lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
`ifdef FLOOR_SPEEDUP_EN
                        wrapCnt <= wrapSum[3:0];
                        if (wrapSum[4] && speedReg != 3'd4) speedReg <= speedReg + 3'd1;
`endif
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_floor_scroller.sv
// Testbench for floor_scroller: behavioural model checked every cycle plus literal pins.
module tb_floor_scroller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        stop = 1'b0;
    logic [29:0] floorsYPos;
    logic [29:0] gapsPos;
    logic [29:0] gapsWidth;
    logic [2:0]  speed;
    logic [9:0]  floorsPassed;

    int asserts = 0;
    int fails = 0;

    floor_scroller #(.SPACING(150), .SPAN(450), .LFSR_SEED(10'h2A5)) dut (
        .clk(clk), .rst_n(rst_n), .frame(frame), .start(start), .pause(pause), .stop(stop),
        .floorsYPos(floorsYPos), .gapsPos(gapsPos), .gapsWidth(gapsWidth),
        .speed(speed), .floorsPassed(floorsPassed)
    );

    always #5 clk = ~clk;

    // Behavioural model in plain integers
    int my [3];
    int mg [3];
    int mw [3];
    int mSpeed, mFp, mLfsr, mWrapCnt;
    bit mRun, mFrameD;

    function automatic int lfsrNext(input int v);
        return ((v << 1) & 1023) | (((v >> 9) ^ (v >> 6)) & 1);
    endfunction

    task automatic mLayout();
        my[0] = 100; my[1] = 250; my[2] = 400;
        mg[0] = 200; mg[1] = 300; mg[2] = 150;
        mw[0] = 40;  mw[1] = 35;  mw[2] = 60;
        mSpeed = 1; mFp = 0; mWrapCnt = 0; mRun = 0;
    endtask

    task automatic mScroll();
        int wraps;
        wraps = 0;
        for (int i = 0; i < 3; i++) begin
            if (my[i] >= mSpeed) my[i] = my[i] - mSpeed;
            else begin
                my[i] = my[i] + 450 - mSpeed;
                mg[i] = 40 + (mLfsr % 512);
                mw[i] = 30 + (mLfsr % 32);
                wraps++;
            end
        end
        if (wraps > 0) mLfsr = lfsrNext(mLfsr);
        mFp = (mFp + wraps > 999) ? 999 : mFp + wraps;
`ifdef FLOOR_SPEEDUP_EN
        mWrapCnt = mWrapCnt + wraps;
        if (mWrapCnt >= 16) begin
            mWrapCnt = mWrapCnt - 16;
            if (mSpeed < 4) mSpeed++;
        end
`endif
    endtask

    task automatic mStep();
        bit edgeNow;
        if (!rst_n) begin
            mLayout();
            mLfsr = 'h2A5;
            mFrameD = 0;
        end else begin
            edgeNow = frame && !mFrameD;
            mFrameD = frame;
            if (stop) mLayout();
            else if (!mRun) begin
                if (start) mRun = 1;
            end else if (edgeNow && !pause) mScroll();
        end
    endtask

    initial begin
        mLayout();
        mLfsr = 'h2A5;
        mFrameD = 0;
    end

    always @(posedge clk or negedge rst_n) mStep();

    task automatic chk(input string name, input logic [29:0] act, input logic [29:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model floorsYPos", floorsYPos, {10'(my[0]), 10'(my[1]), 10'(my[2])});
        chk("model gapsPos", gapsPos, {10'(mg[0]), 10'(mg[1]), 10'(mg[2])});
        chk("model gapsWidth", gapsWidth, {10'(mw[0]), 10'(mw[1]), 10'(mw[2])});
        chk("model speed", {27'd0, speed}, 30'(mSpeed));
        chk("model floorsPassed", {20'd0, floorsPassed}, 30'(mFp));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frameEdges(input int n);
        for (int k = 0; k < n; k++) begin
            frame = 1'b1; tick();
            frame = 1'b0; tick();
        end
    endtask

    task automatic pulseStart();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulseStop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic chkResetLayout(input string tag);
        chk({tag, " y"}, floorsYPos, {10'd100, 10'd250, 10'd400});
        chk({tag, " gap"}, gapsPos, {10'd200, 10'd300, 10'd150});
        chk({tag, " width"}, gapsWidth, {10'd40, 10'd35, 10'd60});
        chk({tag, " passed"}, {20'd0, floorsPassed}, 30'd0);
        chk({tag, " speed"}, {27'd0, speed}, 30'd1);
    endtask

    initial begin
        repeat (3) tick();
        chkResetLayout("reset");
        rst_n = 1'b1;
        tick();

        pulseStart();
        frameEdges(1);
        chk("first edge y", floorsYPos, {10'd99, 10'd249, 10'd399});
        chk("first edge gap", gapsPos, {10'd200, 10'd300, 10'd150});
        chk("first edge speed", {27'd0, speed}, 30'd1);

        frameEdges(100);
        chk("wrap y", floorsYPos, {10'd449, 10'd149, 10'd299});
        chk("wrap gap", gapsPos, {10'd205, 10'd300, 10'd150});
        chk("wrap width", gapsWidth, {10'd35, 10'd35, 10'd60});
        chk("wrap passed", {20'd0, floorsPassed}, 30'd1);
        chk("model pin y0", 30'(my[0]), 30'd449);
        chk("model pin gap0", 30'(mg[0]), 30'd205);

        frame = 1'b1;
        repeat (10) tick();
        frame = 1'b0;
        tick();
        chk("held frame y", floorsYPos, {10'd448, 10'd148, 10'd298});

        pause = 1'b1;
        frameEdges(5);
        pause = 1'b0;
        tick();
        chk("paused y", floorsYPos, {10'd448, 10'd148, 10'd298});

        pulseStop();
        chkResetLayout("stop");

        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        frameEdges(2);
        chkResetLayout("idle start+stop");

        // LFSR continues from its post-wrap value after stop
        pulseStart();
        frameEdges(101);
        chk("reseed y", floorsYPos, {10'd449, 10'd149, 10'd299});
        chk("no reseed gap", gapsPos, {10'd371, 10'd300, 10'd150});
        chk("no reseed width", gapsWidth, {10'd41, 10'd35, 10'd60});

        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chkResetLayout("run start+stop");
        frameEdges(1);
        chk("idle after stop", floorsYPos, {10'd100, 10'd250, 10'd400});

        pulseStart();
        frameEdges(5000);
`ifdef FLOOR_SPEEDUP_EN
        chk("speed saturated", {27'd0, speed}, 30'd4);
`else
        chk("speed constant", {27'd0, speed}, 30'd1);
`endif

        // Reset asserted across an update edge
        frame = 1'b1;
        #3 rst_n = 1'b0;
        #1 chkResetLayout("async reset");
        @(posedge clk);
        #2 chkResetLayout("reset over edge");
        #5 rst_n = 1'b1;
        tick();
        frame = 1'b0;
        frameEdges(2);
        chkResetLayout("post reset idle");

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
